dispatch_unit: RTL

- Parametrised issue-stage dispatcher for the Tomasulo core. It sits between the decoder/regfile read and the ALU RS, Branch RS and LS buffer.
- Allocates a free RS/LS tag internally and renames rd in the regfile. Captures CDB results that arrive in the dispatch cycle.
- Issues registered one-cycle enable pulses to exactly one unit, with a valid/ready stall handshake to the decoder and a flush on mispredict.

---
 rtl/dispatch_unit_pkg.sv | 47 ++++
 rtl/dispatch_unit_if.sv | 56 +++++
 rtl/free_tag_picker.sv | 23 ++
 rtl/dispatch_unit.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/dispatch_unit_pkg.sv
// rtl/dispatch_unit_pkg.sv - shared class codes, tag prefixes and free values for the dispatcher
package dispatch_unit_pkg;

    typedef enum logic [3:0] {
        CLASS_LUI   = 4'd0,
        CLASS_AUIPC = 4'd1,
        CLASS_JAL   = 4'd2,
        CLASS_JALR  = 4'd3,
        CLASS_B     = 4'd4,
        CLASS_LD    = 4'd5,
        CLASS_ST    = 4'd6,
        CLASS_RI    = 4'd7,
        CLASS_RR    = 4'd8
    } op_class_e;

    typedef enum logic [1:0] {
        UNIT_NONE,
        UNIT_ALU,
        UNIT_BRANCH,
        UNIT_LS
    } unit_e;

    // Tag prefixes; an all-zero tag (prefix 00) means "value present, no producer".
    localparam logic [1:0] PREFIX_FREE = 2'b00;
    localparam logic [1:0] PREFIX_ALU  = 2'b01;
    localparam logic [1:0] PREFIX_LS   = 2'b10;

    localparam int unsigned NOP       = 0;
    localparam int unsigned DATA_FREE = 0;
    localparam int unsigned NAME_FREE = 0;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    // Unknown class codes map to UNIT_NONE so they can never be accepted.
    function automatic unit_e class_unit(input logic [3:0] cls);
        unit_e u;
        case (cls)
            CLASS_LUI, CLASS_AUIPC, CLASS_JAL, CLASS_JALR, CLASS_RI, CLASS_RR: u = UNIT_ALU;
            CLASS_B:                                                          u = UNIT_BRANCH;
            CLASS_LD, CLASS_ST:                                               u = UNIT_LS;
            default:                                                          u = UNIT_NONE;
        endcase
        return u;
    endfunction

endpackage

// File: rtl/dispatch_unit_if.sv
// rtl/dispatch_unit_if.sv - decoder, status, CDB and issue signals of the dispatcher
// master: decoder/environment side; slave: dispatch_unit side.
interface dispatch_unit_if #(
    parameter int DATA_W    = 32,
    parameter int NAME_W    = 5,
    parameter int OP_W      = 6,
    parameter int ALU_DEPTH = 16,
    parameter int LS_DEPTH  = 16,
    parameter int IDX_W     = 4,
    parameter int TAG_W     = IDX_W + 2
);
    logic                 flush, inValid, inReady;
    logic [3:0]           opClass;
    logic [OP_W-1:0]      opCode;
    logic [NAME_W-1:0]    rdName, regNameO, regNameT;
    logic [DATA_W-1:0]    imm, Uimm, Jimm, Simm, Bimm;
    logic [TAG_W-1:0]     regTagO, regTagT;
    logic [DATA_W-1:0]    regDataO, regDataT;
    logic [ALU_DEPTH-1:0] ALUfreeStatus;
    logic [LS_DEPTH-1:0]  LSfreeStatus;
    logic                 BranchFree;
    logic                 cdbValid;
    logic [TAG_W-1:0]     cdbTag;
    logic [DATA_W-1:0]    cdbData;

    logic                 enWrt;
    logic [TAG_W-1:0]     wrtTag;
    logic [NAME_W-1:0]    wrtName;
    logic                 ALUen, BranchEn, LSen;
    logic [DATA_W-1:0]    ALUoperandO, ALUoperandT, BranchOperandO, BranchOperandT, LSoperandO, LSoperandT;
    logic [TAG_W-1:0]     ALUtagO, ALUtagT, BranchTagO, BranchTagT, LStagO, LStagT;
    logic [TAG_W-1:0]     ALUtagW, LStagW;
    logic [NAME_W-1:0]    ALUnameW, LSnameW;
    logic [OP_W-1:0]      ALUop, BranchOp, LSop;
    logic [DATA_W-1:0]    BranchImm, LSimm;

    modport master (
        output flush, inValid, opClass, opCode, rdName, regNameO, regNameT,
               imm, Uimm, Jimm, Simm, Bimm, regTagO, regTagT, regDataO, regDataT,
               ALUfreeStatus, LSfreeStatus, BranchFree, cdbValid, cdbTag, cdbData,
        input  inReady, enWrt, wrtTag, wrtName, ALUen, BranchEn, LSen,
               ALUoperandO, ALUoperandT, BranchOperandO, BranchOperandT, LSoperandO, LSoperandT,
               ALUtagO, ALUtagT, BranchTagO, BranchTagT, LStagO, LStagT, ALUtagW, LStagW,
               ALUnameW, LSnameW, ALUop, BranchOp, LSop, BranchImm, LSimm
    );

    modport slave (
        input  flush, inValid, opClass, opCode, rdName, regNameO, regNameT,
               imm, Uimm, Jimm, Simm, Bimm, regTagO, regTagT, regDataO, regDataT,
               ALUfreeStatus, LSfreeStatus, BranchFree, cdbValid, cdbTag, cdbData,
        output inReady, enWrt, wrtTag, wrtName, ALUen, BranchEn, LSen,
               ALUoperandO, ALUoperandT, BranchOperandO, BranchOperandT, LSoperandO, LSoperandT,
               ALUtagO, ALUtagT, BranchTagO, BranchTagT, LStagO, LStagT, ALUtagW, LStagW,
               ALUnameW, LSnameW, ALUop, BranchOp, LSop, BranchImm, LSimm
    );
endinterface

// File: rtl/free_tag_picker.sv
// rtl/free_tag_picker.sv - lowest free slot index of (free_vec & ~pending)
// Ports: free_vec/pending in (DEPTH), idx out (IDX_W), any_free out.
module free_tag_picker #(
    parameter int DEPTH = 16,
    parameter int IDX_W = 4
) (
    input  logic [DEPTH-1:0] free_vec,
    input  logic [DEPTH-1:0] pending,
    output logic [IDX_W-1:0] idx,
    output logic             any_free
);
    logic [DEPTH-1:0] eff;

    always_comb begin
        eff = free_vec & ~pending;
        idx = '0;
        // Walk downwards so the lowest set bit is the last one written.
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (eff[i]) idx = IDX_W'(i);
        end
        any_free = |eff;
    end
endmodule

// File: rtl/dispatch_unit.sv
// rtl/dispatch_unit.sv - Tomasulo issue-stage dispatcher to ALU RS, Branch RS and LS buffer
// Ports: clk, rst (sync active-high), bus (dispatch_unit_if.slave): decoder handshake,
// regfile sources, unit free status, CDB snoop in; registered issue pulses, operands and rename out.
module dispatch_unit
    import dispatch_unit_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int NAME_W    = 5,
    parameter int OP_W      = 6,
    parameter int ALU_DEPTH = 16,
    parameter int LS_DEPTH  = 16,
    parameter int IDX_W     = 4,
    parameter int TAG_W     = IDX_W + 2
) (
    input logic           clk,
    input logic           rst,
    dispatch_unit_if.slave bus
);
    localparam logic [TAG_W-1:0] TAG_FREE = {PREFIX_FREE, {IDX_W{1'b0}}};

    // Slot issued last cycle; the unit's free status does not show it yet.
    logic [ALU_DEPTH-1:0] pend_alu;
    logic [LS_DEPTH-1:0]  pend_ls;
    logic [IDX_W-1:0]     alu_idx, ls_idx;
    logic                 alu_any, ls_any;

    free_tag_picker #(.DEPTH(ALU_DEPTH), .IDX_W(IDX_W)) u_alu_pick (
        .free_vec(bus.ALUfreeStatus), .pending(pend_alu), .idx(alu_idx), .any_free(alu_any)
    );
    free_tag_picker #(.DEPTH(LS_DEPTH), .IDX_W(IDX_W)) u_ls_pick (
        .free_vec(bus.LSfreeStatus), .pending(pend_ls), .idx(ls_idx), .any_free(ls_any)
    );

    op_class_e         cls;
    unit_e             unit;
    logic              avail, fire;
    logic [DATA_W-1:0] op_o, op_t;
    logic [TAG_W-1:0]  tag_o, tag_t;
    logic [TAG_W-1:0]  alu_tag_new, ls_tag_new;
    logic              unused_names;

    assign alu_tag_new  = {PREFIX_ALU, alu_idx};
    assign ls_tag_new   = {PREFIX_LS, ls_idx};
    assign unused_names = ^{bus.regNameO, bus.regNameT};

    always_comb begin
        cls  = op_class_e'(bus.opClass);
        unit = class_unit(bus.opClass);
        case (unit)
            UNIT_ALU:    avail = alu_any;
            UNIT_BRANCH: avail = bus.BranchFree;
            UNIT_LS:     avail = ls_any;
            default:     avail = 1'b0;
        endcase
        fire = bus.inValid & ~bus.flush & ~rst & avail;

        // A result broadcast in the dispatch cycle would otherwise be missed by the RS.
        op_o  = bus.regDataO;
        tag_o = bus.regTagO;
        if (bus.cdbValid && bus.regTagO != TAG_FREE && bus.cdbTag == bus.regTagO) begin
            op_o  = bus.cdbData;
            tag_o = TAG_FREE;
        end

        op_t  = bus.imm;
        tag_t = TAG_FREE;
        case (cls)
            CLASS_RR, CLASS_B, CLASS_ST: begin
                op_t  = bus.regDataT;
                tag_t = bus.regTagT;
                if (bus.cdbValid && bus.regTagT != TAG_FREE && bus.cdbTag == bus.regTagT) begin
                    op_t  = bus.cdbData;
                    tag_t = TAG_FREE;
                end
            end
            CLASS_LUI, CLASS_AUIPC: op_t = bus.Uimm;
            CLASS_JAL:              op_t = bus.Jimm;
            default:                ;
        endcase
    end

    assign bus.inReady = fire;

    always_ff @(posedge clk) begin
        bus.ALUen    <= DISABLE;
        bus.BranchEn <= DISABLE;
        bus.LSen     <= DISABLE;
        bus.enWrt    <= DISABLE;
        pend_alu     <= '0;
        pend_ls      <= '0;

        // Units not targeted by a fire are returned to free values; otherwise data holds.
        if (rst || fire) begin
            bus.wrtTag         <= TAG_FREE;
            bus.wrtName        <= NAME_W'(NAME_FREE);
            bus.ALUoperandO    <= DATA_W'(DATA_FREE);
            bus.ALUoperandT    <= DATA_W'(DATA_FREE);
            bus.ALUtagO        <= TAG_FREE;
            bus.ALUtagT        <= TAG_FREE;
            bus.ALUtagW        <= TAG_FREE;
            bus.ALUnameW       <= NAME_W'(NAME_FREE);
            bus.ALUop          <= OP_W'(NOP);
            bus.BranchOperandO <= DATA_W'(DATA_FREE);
            bus.BranchOperandT <= DATA_W'(DATA_FREE);
            bus.BranchTagO     <= TAG_FREE;
            bus.BranchTagT     <= TAG_FREE;
            bus.BranchOp       <= OP_W'(NOP);
            bus.BranchImm      <= DATA_W'(DATA_FREE);
            bus.LSoperandO     <= DATA_W'(DATA_FREE);
            bus.LSoperandT     <= DATA_W'(DATA_FREE);
            bus.LStagO         <= TAG_FREE;
            bus.LStagT         <= TAG_FREE;
            bus.LStagW         <= TAG_FREE;
            bus.LSnameW        <= NAME_W'(NAME_FREE);
            bus.LSop           <= OP_W'(NOP);
            bus.LSimm          <= DATA_W'(DATA_FREE);
        end

        if (fire) begin
            case (unit)
                UNIT_ALU: begin
                    bus.ALUen       <= ENABLE;
                    pend_alu        <= ALU_DEPTH'(1) << alu_idx;
                    bus.ALUoperandO <= op_o;
                    bus.ALUoperandT <= op_t;
                    bus.ALUtagO     <= tag_o;
                    bus.ALUtagT     <= tag_t;
                    bus.ALUtagW     <= alu_tag_new;
                    bus.ALUnameW    <= bus.rdName;
                    bus.ALUop       <= bus.opCode;
                    // x0 is never renamed but the slot is still consumed.
                    if (bus.rdName != '0) begin
                        bus.enWrt   <= ENABLE;
                        bus.wrtTag  <= alu_tag_new;
                        bus.wrtName <= bus.rdName;
                    end
                end
                UNIT_BRANCH: begin
                    bus.BranchEn       <= ENABLE;
                    bus.BranchOperandO <= op_o;
                    bus.BranchOperandT <= op_t;
                    bus.BranchTagO     <= tag_o;
                    bus.BranchTagT     <= tag_t;
                    bus.BranchOp       <= bus.opCode;
                    bus.BranchImm      <= bus.Bimm;
                end
                UNIT_LS: begin
                    bus.LSen       <= ENABLE;
                    pend_ls        <= LS_DEPTH'(1) << ls_idx;
                    bus.LSoperandO <= op_o;
                    bus.LSoperandT <= op_t;
                    bus.LStagO     <= tag_o;
                    bus.LStagT     <= tag_t;
                    bus.LSop       <= bus.opCode;
                    if (cls == CLASS_LD) begin
                        bus.LStagW  <= ls_tag_new;
                        bus.LSnameW <= bus.rdName;
                        bus.LSimm   <= bus.imm;
                        if (bus.rdName != '0) begin
                            bus.enWrt   <= ENABLE;
                            bus.wrtTag  <= ls_tag_new;
                            bus.wrtName <= bus.rdName;
                        end
                    end else begin
                        bus.LSimm <= bus.Simm;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
